// File: rtl/register_file_if.sv
// Register-file bus: two read ports plus the write-back port and the ready flag.
// The core (master) drives indices and write data; the register file (slave) returns read data.
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 5
);
  logic [IDX_W-1:0]      read_reg1;
  logic [IDX_W-1:0]      read_reg2;
  logic [IDX_W-1:0]      write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  reg_write;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;
  logic                  ready;

  modport master (
    output read_reg1, read_reg2, write_reg, write_data, reg_write,
    input  read_data1, read_data2, ready
  );

  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, reg_write,
    output read_data1, read_data2, ready
  );
endinterface

// File: rtl/register_file.sv
// 32 x 32-bit RISC-V integer register file: self-clearing after reset, x0 hardwired
// to zero, two combinational read ports with same-cycle write-to-read bypass.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input logic            clk,
  input logic            reset,
  register_file_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      clear_idx_q, clear_idx_d;
  logic                  ready_q, ready_d;

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  wr_accept;
  logic [DATA_WIDTH-1:0] rd1, rd2;

  assign wr_accept = ready_q && bus.reg_write && (bus.write_reg != '0);

  // NOTE: every signal written here gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    ready_d     = ready_q;
    mem_we      = 1'b0;
    mem_waddr   = clear_idx_q;
    mem_wdata   = '0;

    unique case (state_q)
      ST_CLEAR: begin
        mem_we      = 1'b1;
        clear_idx_d = clear_idx_q + IDX_W'(1);
        if (clear_idx_q == IDX_W'(NUM_REGS - 1)) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (wr_accept) begin
          mem_we    = 1'b1;
          mem_waddr = bus.write_reg;
          mem_wdata = bus.write_data;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clear_idx_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
      ready_q     <= ready_d;
    end
  end

  // NOTE: the array has no reset branch; it is zeroed by the CLEAR walk instead,
  // which keeps it mappable onto plain RAM/flop arrays without a reset tree.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Reads are masked until the clear walk finishes, so stale contents never leak.
  always_comb begin
    rd1 = '0;
    if (ready_q && (bus.read_reg1 != '0)) begin
      rd1 = (wr_accept && (bus.write_reg == bus.read_reg1)) ? bus.write_data
                                                            : mem[bus.read_reg1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (ready_q && (bus.read_reg2 != '0)) begin
      rd2 = (wr_accept && (bus.write_reg == bus.read_reg2)) ? bus.write_data
                                                            : mem[bus.read_reg2];
    end
  end

  assign bus.read_data1 = rd1;
  assign bus.read_data2 = rd2;
  assign bus.ready      = ready_q;

endmodule
